ifm_window_loader: RTL and testbench
====================================

Name: ifm_window_loader

Overview:
- Upstream feeder for the 3D convolution stage (2 channels x 4x4 window, 32 nibbles consumed in parallel on a single-cycle in_valid).
- Accepts a serial stream of 4-bit IFM pixels over a valid/ready handshake and packs each group of 32 into a flat 128-bit window.
- Ping-pong banks let the next window fill while the previous one is presented, so back-to-back windows have no bubble.

Parameters:
- NUM_PIX, 32, pixels per window (2 ch x 4 x 4).
- PIX_W, 4, bits per pixel.
- CNT_W, 5, width of the fill index; must satisfy 2**CNT_W >= NUM_PIX.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  loader enable; 0 freezes the fill.
- pix_valid  in  1  pixel beat valid.
- pix_data  in  PIX_W  pixel value.
- pix_sof  in  1  marks the first pixel of a window; qualified by an accepted beat.
- pix_ready  out  1  loader can accept a beat.
- conv_valid  out  1  one-cycle pulse: ifm_flat holds a complete window (drives the convolution's in_valid).
- ifm_flat  out  NUM_PIX*PIX_W  packed window; pixel k sits at bits [4k+3:4k], k=0 maps to In_IFM_1.
- err_abort  out  1  one-cycle pulse: partial window discarded.

Behaviour:
- Reset (rst=1 at a clk edge): pix_ready=0, conv_valid=0, err_abort=0, ifm_flat=0, fill index=0, write bank=0, state=IDLE.
- Reset applied mid-window discards the partial window silently; no err_abort.
- Handshake:
  - Accept = pix_valid & pix_ready.
  - pix_ready is registered: pix_ready <= en, so it lags en by one cycle.
  - The source may hold pix_valid with stable data indefinitely.
  - Beats with pix_ready=0 are not consumed.
- States:
  - IDLE: index=0. On an accept, go to FILL.
  - FILL: counting pixels in the current bank.
  - An accepted beat with pix_sof=1 in IDLE loads index 0; sof is not required for the first window.
- Fill:
  - An accepted beat writes pix_data into the write bank at slot = index, then index increments.
  - A stalled or idle cycle leaves index and the bank unchanged.
  - en=0 mid-window keeps the partial window intact; filling resumes where it stopped.
- Completion: an accepted beat at index NUM_PIX-1 with pix_sof=0 does the following.
  - Index wraps to 0 and the write bank toggles.
  - Next cycle: conv_valid=1 for exactly one cycle and ifm_flat = the completed bank.
  - ifm_flat holds that value until the next completion.
  - Latency is 1 cycle from the 32nd accepted beat.
- Back-to-back: 32 consecutive accepts per window yield conv_valid every 32 cycles, and the beat after a completion is accepted in the same cycle conv_valid is high.
- Resync: an accepted beat with pix_sof=1 while index != 0 does the following.
  - The partial window is dropped.
  - The beat is written to slot 0 of the same bank and index becomes 1.
  - err_abort pulses one cycle later.
  - This holds even when index = NUM_PIX-1: the abort wins and there is no conv_valid.
- pix_sof=1 with index=0 is a normal start; no error.
- conv_valid and err_abort are never high in the same cycle.
- The block applies no arithmetic; pixel values pass bit-exact.

Optional Feature:
- Macro: IFM_LOADER_STAT_EN.
- When defined, two extra outputs are added:
  - win_cnt [15:0]: increments on every conv_valid, wraps at 65535 -> 0.
  - abort_cnt [7:0]: increments on every err_abort, saturates at 255.
  - Both counters reset to 0 on rst.
- When undefined, neither port nor the counters exist, and all other behaviour is identical.

Decomposition:
- Package ifm_pkg holds:
  - the NUM_PIX, PIX_W and OFM_W=13 constants;
  - a state enum (IDLE, FILL);
  - a function mapping (channel,row,col) to flat index = ch*16+row*4+col.
- One sub-module, ifm_bank: a NUM_PIX x PIX_W register file with write-enable and index, plus a flat read-out port. It is instantiated twice for the ping-pong banks.

Test Plan:
- Reset, then en=1, then 32 accepted beats with data = k mod 16 (sof on beat 0) -> one cycle after beat 31, conv_valid=1 for one cycle and ifm_flat = 0xFEDCBA9876543210FEDCBA9876543210.
- 96 continuous beats of 0xA -> conv_valid at cycles 32, 64 and 96 after the first accept; ifm_flat all 0xA; pix_ready never drops.
- en=0 after 10 beats for 20 cycles, then resume 22 beats -> exactly one conv_valid; ifm_flat slots 0..9 and 10..31 hold the correct data; no err_abort.
- 17 beats, then a beat with pix_sof=1 and data 0x5 -> err_abort pulse next cycle; the following 31 beats complete a window with slot 0 = 0x5; no conv_valid before that.
- sof asserted on the 32nd beat -> err_abort, no conv_valid.
- rst asserted for 1 cycle mid-window (index 20) -> all outputs 0, no err_abort; the next 32 beats produce a clean window.
- With IFM_LOADER_STAT_EN defined, 3 windows plus 2 aborts -> win_cnt=3, abort_cnt=2.

Source files
------------

// File: rtl/ifm_pkg.sv
// Shared constants, FSM state type and window index helper for the IFM window loader.
package ifm_pkg;

    localparam int NUM_PIX = 32;
    localparam int PIX_W   = 4;
    localparam int CNT_W   = 5;
    localparam int OFM_W   = 13;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    // Flat slot of a window element: ch*16 + row*4 + col.
    function automatic logic [CNT_W-1:0] pix_index(input logic       ch,
                                                   input logic [1:0] row,
                                                   input logic [1:0] col);
        return CNT_W'(ch) * CNT_W'(16) + CNT_W'(row) * CNT_W'(4) + CNT_W'(col);
    endfunction

endpackage

// File: rtl/ifm_window_loader_bank.sv
// One ping-pong bank: NUM_PIX x PIX_W register file, indexed write, flat read-out.
module ifm_bank
    import ifm_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_we,
    input  logic [CNT_W-1:0]         i_idx,
    input  logic [PIX_W-1:0]         i_data,
    output logic [NUM_PIX*PIX_W-1:0] o_flat
);

    logic [NUM_PIX-1:0][PIX_W-1:0] r_mem;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_mem <= '0;
        else if (i_we)
            r_mem[i_idx] <= i_data;
    end

    assign o_flat = r_mem;

endmodule

// File: rtl/ifm_window_loader.sv
// Packs a serial 4-bit pixel stream into 128-bit convolution windows via ping-pong banks.
// Optional IFM_LOADER_STAT_EN adds window / abort counters.
module ifm_window_loader
    import ifm_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_en,
    input  logic                     i_pix_valid,
    input  logic [PIX_W-1:0]         i_pix_data,
    input  logic                     i_pix_sof,
    output logic                     o_pix_ready,
    output logic                     o_conv_valid,
    output logic [NUM_PIX*PIX_W-1:0] o_ifm_flat,
    output logic                     o_err_abort
`ifdef IFM_LOADER_STAT_EN
   ,output logic [15:0]              o_win_cnt,
    output logic [7:0]               o_abort_cnt
`endif
);

    state_t              r_state;
    logic [CNT_W-1:0]    r_idx;
    logic                r_wbank;
    logic                r_have;
    logic                r_ready;
    logic                r_conv_valid;
    logic                r_err;

    logic                w_acc;
    logic                w_resync;
    logic                w_done;
    logic [CNT_W-1:0]    w_slot;
    logic [NUM_PIX*PIX_W-1:0] w_flat0;
    logic [NUM_PIX*PIX_W-1:0] w_flat1;

    assign w_acc    = i_pix_valid & r_ready;
    assign w_resync = w_acc & i_pix_sof & (r_idx != '0);
    assign w_done   = w_acc & ~i_pix_sof & (r_idx == CNT_W'(NUM_PIX-1));
    // A sof beat always restarts at slot 0, dropping any partial window.
    assign w_slot   = ((r_state == IDLE) || i_pix_sof) ? '0 : r_idx;

    ifm_bank u_bank0 (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_we   (w_acc & ~r_wbank),
        .i_idx  (w_slot),
        .i_data (i_pix_data),
        .o_flat (w_flat0)
    );

    ifm_bank u_bank1 (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_we   (w_acc & r_wbank),
        .i_idx  (w_slot),
        .i_data (i_pix_data),
        .o_flat (w_flat1)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_wbank      <= 1'b0;
            r_have       <= 1'b0;
            r_ready      <= 1'b0;
            r_conv_valid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_ready      <= i_en;
            r_conv_valid <= w_done;
            r_err        <= w_resync;
            if (w_acc) begin
                if (w_done) begin
                    r_idx   <= '0;
                    r_wbank <= ~r_wbank;
                    r_have  <= 1'b1;
                    r_state <= IDLE;
                end else begin
                    r_idx   <= w_slot + CNT_W'(1);
                    r_state <= FILL;
                end
            end
        end
    end

    // The completed bank is the one not being written; it is untouched until the next toggle.
    assign o_ifm_flat   = !r_have ? '0 : (r_wbank ? w_flat0 : w_flat1);
    assign o_pix_ready  = r_ready;
    assign o_conv_valid = r_conv_valid;
    assign o_err_abort  = r_err;

`ifdef IFM_LOADER_STAT_EN
    logic [15:0] r_win_cnt;
    logic [7:0]  r_abort_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_win_cnt   <= '0;
            r_abort_cnt <= '0;
        end else begin
            if (r_conv_valid)
                r_win_cnt <= r_win_cnt + 16'd1;
            if (r_err && (r_abort_cnt != 8'hFF))
                r_abort_cnt <= r_abort_cnt + 8'd1;
        end
    end

    assign o_win_cnt   = r_win_cnt;
    assign o_abort_cnt = r_abort_cnt;
`endif

endmodule

// File: tb/tb_ifm_window_loader.sv
// Scoreboard bench for ifm_window_loader: pixel-list reference model, decoupled pulse monitor.
module tb_ifm_window_loader;
    import ifm_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         pix_valid = 1'b0;
    logic         pix_sof = 1'b0;
    logic [3:0]   pix_data = 4'h0;
    logic         pix_ready, conv_valid, err_abort;
    logic [127:0] ifm_flat;
`ifdef IFM_LOADER_STAT_EN
    logic [15:0]  win_cnt;
    logic [7:0]   abort_cnt;
`endif

    ifm_window_loader dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_pix_valid  (pix_valid),
        .i_pix_data   (pix_data),
        .i_pix_sof    (pix_sof),
        .o_pix_ready  (pix_ready),
        .o_conv_valid (conv_valid),
        .o_ifm_flat   (ifm_flat),
        .o_err_abort  (err_abort)
`ifdef IFM_LOADER_STAT_EN
       ,.o_win_cnt    (win_cnt),
        .o_abort_cnt  (abort_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           is_win;
        logic [127:0] flat;
        int           due;
    } ev_t;

    ev_t          exp_q[$];
    logic [3:0]   win[$];
    logic [127:0] exp_flat = '0;
    logic [127:0] f;
    int           total = 0, bad = 0, cyc = 0;
    int           win_m = 0, ab_m = 0;
    bit           ready_m = 0, acc_flag = 0, mon_on = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: windows are simply lists of accepted pixels.
    always @(posedge clk) begin
        cyc++;
        acc_flag = 0;
        if (rst) begin
            ready_m = 0;
            win.delete();
            exp_q.delete();
            exp_flat = '0;
            win_m = 0;
            ab_m = 0;
        end else begin
            if (pix_valid && ready_m) begin
                acc_flag = 1;
                if (pix_sof && win.size() != 0) begin
                    exp_q.push_back('{1'b0, '0, cyc});
                    win.delete();
                    ab_m = (ab_m == 255) ? 255 : ab_m + 1;
                end
                win.push_back(pix_data);
                if (win.size() == NUM_PIX) begin
                    f = '0;
                    foreach (win[k]) f[k*4 +: 4] = win[k];
                    exp_q.push_back('{1'b1, f, cyc});
                    exp_flat = f;
                    win.delete();
                    win_m = (win_m + 1) % 65536;
                end
            end
            ready_m = en;
        end
    end

    // Monitor: compare outputs against the model on the falling edge.
    always @(negedge clk) begin
        ev_t e;
        if (mon_on) begin
            chk("pix_ready", {127'b0, pix_ready}, {127'b0, ready_m});
            chk("ifm_flat", ifm_flat, exp_flat);
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                if (e.is_win) begin
                    chk("conv_valid_pulse", {127'b0, conv_valid}, 128'd1);
                    chk("no_abort_on_win", {127'b0, err_abort}, 128'd0);
                    chk("win_data", ifm_flat, e.flat);
                end else begin
                    chk("err_abort_pulse", {127'b0, err_abort}, 128'd1);
                    chk("no_conv_on_abort", {127'b0, conv_valid}, 128'd0);
                end
            end else begin
                chk("conv_valid_idle", {127'b0, conv_valid}, 128'd0);
                chk("err_abort_idle", {127'b0, err_abort}, 128'd0);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [3:0] d, input bit s);
        int n = 0;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_sof   = s;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!acc_flag && n < 100);
        if (!acc_flag) begin
            total++;
            bad++;
            $display("FAIL beat_accept timeout after %0d cycles, expected an accept", n);
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic beats(input int n);
        for (int i = 0; i < n; i++) beat(4'($urandom), 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_on = 1;
        idle(1);
        en = 1'b1;
        idle(2);

        // counting pattern -> FEDCBA9876543210 twice
        for (int k = 0; k < 32; k++) beat(4'(k % 16), k == 0);
        idle(3);

        // continuous 0xA stream
        for (int k = 0; k < 96; k++) beat(4'hA, 1'b0);
        idle(3);

        // en pause mid-window
        beats(10);
        en = 1'b0;
        idle(20);
        en = 1'b1;
        beats(22);
        idle(3);

        // resync after 17 beats
        beats(17);
        beat(4'h5, 1'b1);
        beats(31);
        idle(3);

        // sof on the 32nd beat
        beats(31);
        beat(4'h3, 1'b1);
        beats(31);
        idle(3);

        // reset mid-window
        beats(20);
        do_reset();
        beats(32);
        idle(3);

        // 3 windows and 2 aborts from a clean state
        for (int w = 0; w < 3; w++) begin
            beats(5);
            if (w < 2) beat(4'($urandom), 1'b1);
            beats(w < 2 ? 31 : 27);
        end
        idle(3);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                en = ($urandom_range(0, 3) != 0);
                idle($urandom_range(1, 4));
            end
            en = 1'b1;
            beat(4'($urandom), $urandom_range(0, 39) == 0);
        end
        idle(5);

`ifdef IFM_LOADER_STAT_EN
        chk("win_cnt", {112'b0, win_cnt}, 128'(win_m));
        chk("abort_cnt", {120'b0, abort_cnt}, 128'(ab_m));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
